// File: rtl/pixel_copy_pkg.sv
// pixel_copy_pkg: shared state encoding, mode encoding and counter width for the pixel copy engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pixel_copy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_COPY  = 2'b00;
    localparam logic [1:0] MODE_INV   = 2'b01;
    localparam logic [1:0] MODE_FILL  = 2'b10;
    localparam logic [1:0] MODE_COPY2 = 2'b11;

    // Row/column counters and destination coordinates (10-bit offset plus source extent).
    localparam int XY_W = 16;

endpackage

// File: rtl/pixel_copy_delay.sv
// pixel_copy_delay: DEPTH-stage delay line for the per-pixel valid bit, destination address and clip flag.
// Latency: exactly DEPTH cycles from i_* to o_*.
// Backpressure: none; i_flush empties every stage on the next edge.
module pixel_copy_delay #(
    parameter int ADDR_W = 19,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_vld,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_clip,
    output logic              o_vld,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_clip
);

    logic [DEPTH-1:0]  r_vld;
    logic [DEPTH-1:0]  r_clip;
    logic [ADDR_W-1:0] r_addr [DEPTH];

    // Shift the issued pixel tag one stage per cycle; flush or reset empties the line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld  <= '0;
            r_clip <= '0;
            for (int i = 0; i < DEPTH; i++) r_addr[i] <= '0;
        end else if (i_flush) begin
            r_vld  <= '0;
            r_clip <= '0;
            for (int i = 0; i < DEPTH; i++) r_addr[i] <= '0;
        end else begin
            r_vld[0]  <= i_vld;
            r_clip[0] <= i_clip;
            r_addr[0] <= i_addr;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_clip[i] <= r_clip[i-1];
                r_addr[i] <= r_addr[i-1];
            end
        end
    end

    assign o_vld  = r_vld[DEPTH-1];
    assign o_clip = r_clip[DEPTH-1];
    assign o_addr = r_addr[DEPTH-1];

endmodule

// File: rtl/pixel_copy_engine.sv
// pixel_copy_engine: blits a SRC_W x SRC_H image into a DST_W x DST_H frame at (dst_x,dst_y); copy/invert/fill with clipping. Fill needs PIXEL_COPY_FILL_EN.
// Latency: one pixel per cycle; start -> done is SRC_W*SRC_H + RD_LAT + 1 cycles; writes trail reads by RD_LAT.
// Backpressure: none; source answers in fixed RD_LAT cycles, destination takes every write; abort flushes immediately.
module pixel_copy_engine #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 19,
    parameter int SRC_W  = 160,
    parameter int SRC_H  = 120,
    parameter int DST_W  = 640,
    parameter int DST_H  = 480,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [9:0]        dst_x,
    input  logic [9:0]        dst_y,
    input  logic [DATA_W-1:0] fill_value,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [DATA_W-1:0] dst_data,
    output logic              dst_wren,
    output logic              busy,
    output logic              done
);
    import pixel_copy_pkg::*;

    localparam logic [XY_W-1:0] COL_LAST = XY_W'(SRC_W - 1);
    localparam logic [XY_W-1:0] ROW_LAST = XY_W'(SRC_H - 1);

    state_t            r_state, w_next;
    logic              w_start, w_issue, w_flush, w_last, w_clip, w_busy, w_done;
    logic [ADDR_W-1:0] r_src_addr, r_row_base, w_issue_addr;
    logic [XY_W-1:0]   r_row, r_col, r_dcol, r_drow, r_dst_x;
    logic [1:0]        r_mode;
    logic [2:0]        r_drain;
    logic              w_dly_vld, w_dly_clip;
    logic [ADDR_W-1:0] w_dly_addr;
    logic [DATA_W-1:0] w_pix;

    assign w_start      = (r_state == ST_IDLE) && start && !abort;
    assign w_last       = (r_row == ROW_LAST) && (r_col == COL_LAST);
    assign w_issue_addr = r_row_base + ADDR_W'(r_dcol);
    assign w_clip       = (r_dcol >= XY_W'(DST_W)) || (r_drow >= XY_W'(DST_H));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state, issue/flush strobes and status outputs.
    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        w_flush = 1'b0;
        w_busy  = (r_state != ST_IDLE);
        w_done  = (r_state == ST_DONE);
        case (r_state)
            ST_IDLE: if (w_start) w_next = ST_RUN;
            ST_RUN: begin
                if (abort) begin
                    w_flush = 1'b1;
                    w_next  = ST_IDLE;
                end else begin
                    w_issue = 1'b1;
                    if (w_last) w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    w_flush = 1'b1;
                    w_next  = ST_IDLE;
                end else if (r_drain == 3'(RD_LAT - 1)) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Raster counters: source address, row-base accumulator and destination coordinates advance per issued pixel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode     <= MODE_COPY;
            r_dst_x    <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_dcol     <= '0;
            r_drow     <= '0;
            r_row_base <= '0;
            r_src_addr <= '0;
            r_drain    <= '0;
        end else if (w_start) begin
            r_mode     <= mode;
            r_dst_x    <= XY_W'(dst_x);
            r_row      <= '0;
            r_col      <= '0;
            r_dcol     <= XY_W'(dst_x);
            r_drow     <= XY_W'(dst_y);
            r_row_base <= ADDR_W'(dst_y) * ADDR_W'(DST_W);
            r_src_addr <= '0;
            r_drain    <= '0;
        end else if (w_issue) begin
            if (!w_last) r_src_addr <= r_src_addr + ADDR_W'(1);
            if (r_col == COL_LAST) begin
                r_col      <= '0;
                r_row      <= r_row + XY_W'(1);
                r_dcol     <= r_dst_x;
                r_drow     <= r_drow + XY_W'(1);
                r_row_base <= r_row_base + ADDR_W'(DST_W);
            end else begin
                r_col  <= r_col + XY_W'(1);
                r_dcol <= r_dcol + XY_W'(1);
            end
        end else if (r_state == ST_DRAIN) begin
            r_drain <= r_drain + 3'd1;
        end
    end

`ifdef PIXEL_COPY_FILL_EN
    logic [DATA_W-1:0] r_fill;

    // Fill pixel is captured with the rest of the job parameters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       r_fill <= '0;
        else if (w_start) r_fill <= fill_value;
    end
`else
    logic w_unused_fill;
    assign w_unused_fill = ^fill_value;
`endif

    // Pixel transform applied to the returning source word.
    always_comb begin
        w_pix = src_data;
        case (r_mode)
            MODE_INV:  w_pix = ~src_data;
`ifdef PIXEL_COPY_FILL_EN
            MODE_FILL: w_pix = r_fill;
`endif
            default:   w_pix = src_data;
        endcase
    end

    pixel_copy_delay #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RD_LAT)
    ) u_delay (
        .clk     (clk),
        .reset   (reset),
        .i_flush (w_flush),
        .i_vld   (w_issue),
        .i_addr  (w_issue_addr),
        .i_clip  (w_clip),
        .o_vld   (w_dly_vld),
        .o_addr  (w_dly_addr),
        .o_clip  (w_dly_clip)
    );

    assign src_addr = r_src_addr;
    assign dst_addr = w_dly_addr;
    assign dst_wren = w_dly_vld & ~w_dly_clip;
    assign dst_data = w_dly_vld ? w_pix : '0;
    assign busy     = w_busy;
    assign done     = w_done;

endmodule

// File: tb/tb_pixel_copy_engine.sv
// tb_pixel_copy_engine: two engines (RD_LAT=1 and RD_LAT=3) against an arithmetic model of the blit.
// Latency: n/a.
// Backpressure: n/a.
module tb_pixel_copy_engine;

    localparam int N = 19200;

    logic        clk = 1'b0;
    logic        reset;
    logic        abort;
    logic [1:0]  st;
    logic [1:0]  mode [2];
    logic [9:0]  dx [2];
    logic [9:0]  dy [2];
    logic [7:0]  fill [2];
    logic [18:0] sa [2];
    logic [18:0] da [2];
    logic [7:0]  sd [2];
    logic [7:0]  dd [2];
    logic        wr [2];
    logic        bsy [2];
    logic        dn [2];
    logic [7:0]  b_p1, b_p2;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    // model state per engine
    bit m_act [2];
    bit m_dok [2];
    int m_s [2];
    int m_e [2];
    int m_wlast [2];
    int m_p [2];
    int m_dx [2];
    int m_dy [2];
    int m_mode [2];
    int m_fill [2];
    // observations per engine
    int o_cnt [2];
    int o_faddr [2];
    int o_fdata [2];
    int o_d5 [2];
    int o_done_cyc [2];
    int o_start_cyc [2];
    int o_ndone [2];

    pixel_copy_engine #(.RD_LAT(1)) u_a (
        .clk(clk), .reset(reset), .start(st[0]), .abort(abort), .mode(mode[0]),
        .dst_x(dx[0]), .dst_y(dy[0]), .fill_value(fill[0]), .src_addr(sa[0]),
        .src_data(sd[0]), .dst_addr(da[0]), .dst_data(dd[0]), .dst_wren(wr[0]),
        .busy(bsy[0]), .done(dn[0])
    );

    pixel_copy_engine #(.RD_LAT(3)) u_b (
        .clk(clk), .reset(reset), .start(st[1]), .abort(abort), .mode(mode[1]),
        .dst_x(dx[1]), .dst_y(dy[1]), .fill_value(fill[1]), .src_addr(sa[1]),
        .src_data(sd[1]), .dst_addr(da[1]), .dst_data(dd[1]), .dst_wren(wr[1]),
        .busy(bsy[1]), .done(dn[1])
    );

    always #5 clk = ~clk;

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] rom(input int a);
        logic [31:0] v;
        v = a;
        return (a == 5) ? 8'h3C : v[7:0];
    endfunction

    function automatic bit clipped(input int i, input int p);
        return (m_dx[i] + p % 160 >= 640) || (m_dy[i] + p / 160 >= 480);
    endfunction

    function automatic int exp_data(input int i, input int p);
        logic [7:0] v, nv;
        v  = rom(p);
        nv = ~v;
        if (m_mode[i] == 1) return int'(nv);
`ifdef PIXEL_COPY_FILL_EN
        if (m_mode[i] == 2) return m_fill[i];
`endif
        return int'(v);
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%0d required=%0d cyc=%0d", name, idx, act, exp, cyc);
        end
    endtask

    // Source memories: fixed read latency of 1 and 3 cycles.
    always @(posedge clk) begin
        sd[0] <= rom(int'(sa[0]));
        b_p1  <= rom(int'(sa[1]));
        b_p2  <= b_p1;
        sd[1] <= b_p2;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle comparison of status and write stream against the model.
    always @(negedge clk) begin : cmp
        bit eb, ed;
        for (int i = 0; i < 2; i++) begin
            eb = m_act[i] && cyc >= m_s[i] && cyc <= m_e[i];
            ed = m_act[i] && m_dok[i] && cyc == m_e[i];
            chk("busy", i, int'(bsy[i]), int'(eb));
            chk("done", i, int'(dn[i]), int'(ed));
            if (dn[i]) begin
                o_ndone[i]++;
                o_done_cyc[i] = cyc;
            end
            if (wr[i]) begin
                while (m_p[i] < N && clipped(i, m_p[i])) m_p[i]++;
                if (m_act[i] && cyc >= m_s[i] && cyc <= m_wlast[i] && m_p[i] < N) begin
                    chk("wr_addr", i, int'(da[i]),
                        (m_dy[i] + m_p[i] / 160) * 640 + m_dx[i] + m_p[i] % 160);
                    chk("wr_data", i, int'(dd[i]), exp_data(i, m_p[i]));
                    m_p[i]++;
                end else begin
                    chk("unexpected_wr", i, 1, 0);
                end
                if (o_cnt[i] == 0) begin
                    o_faddr[i] = int'(da[i]);
                    o_fdata[i] = int'(dd[i]);
                end
                if (da[i] == 19'd5) o_d5[i] = int'(dd[i]);
                o_cnt[i]++;
            end
        end
    end

    task automatic arm(input int i, input int md, input int x, input int y, input int f);
        mode[i] = 2'(md);
        dx[i]   = 10'(x);
        dy[i]   = 10'(y);
        fill[i] = 8'(f);
        st[i]   = 1'b1;
        m_act[i] = 1'b1;
        m_dok[i] = 1'b1;
        m_s[i]   = cyc + 1;
        m_e[i]   = cyc + 1 + N + lat(i);
        m_wlast[i] = m_e[i] - 1;
        m_p[i]   = 0;
        m_dx[i]  = x;
        m_dy[i]  = y;
        m_mode[i] = md;
        m_fill[i] = f;
        o_cnt[i] = 0;
        o_faddr[i] = -1;
        o_fdata[i] = -1;
        o_d5[i] = -1;
        o_done_cyc[i] = -1;
        o_start_cyc[i] = cyc;
        o_ndone[i] = 0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fin(input int i);
        while (m_p[i] < N && clipped(i, m_p[i])) m_p[i]++;
        chk("all_written", i, m_p[i], N);
    endtask

    task automatic check_idle_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_src_addr"}, i, int'(sa[i]), 0);
            chk({tag, "_dst_addr"}, i, int'(da[i]), 0);
            chk({tag, "_dst_data"}, i, int'(dd[i]), 0);
            chk({tag, "_dst_wren"}, i, int'(wr[i]), 0);
            chk({tag, "_busy"},     i, int'(bsy[i]), 0);
            chk({tag, "_done"},     i, int'(dn[i]), 0);
        end
    endtask

    initial begin
        reset = 1'b0;
        abort = 1'b0;
        st    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            mode[i] = 2'b00; dx[i] = '0; dy[i] = '0; fill[i] = '0;
            m_act[i] = 1'b0; m_dok[i] = 1'b0; m_s[i] = 0; m_e[i] = 0; m_wlast[i] = 0;
            m_p[i] = 0; m_dx[i] = 0; m_dy[i] = 0; m_mode[i] = 0; m_fill[i] = 0;
            o_cnt[i] = 0; o_faddr[i] = -1; o_fdata[i] = -1; o_d5[i] = -1;
            o_done_cyc[i] = -1; o_start_cyc[i] = 0; o_ndone[i] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero("rst");
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // A: copy at origin (with an ignored start mid-run); B: invert at origin
        arm(0, 0, 0, 0, 0);
        arm(1, 1, 0, 0, 0);
        @(posedge clk); #1;
        st = 2'b00;
        wait_cyc(m_s[0] + 50);
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        wait_cyc(m_e[1] + 2);
        chk("lat_copy", 0, o_done_cyc[0] - o_start_cyc[0], 19202);
        chk("nwr_copy", 0, o_cnt[0], 19200);
        chk("d5_copy",  0, o_d5[0], 'h3C);
        fin(0);
        chk("lat_inv", 1, o_done_cyc[1] - o_start_cyc[1], 19204);
        chk("nwr_inv", 1, o_cnt[1], 19200);
        chk("d5_inv",  1, o_d5[1], 'hC3);
        fin(1);

        // A: copy at (600,400), mostly clipped; B: fill 0xAA at origin
        arm(0, 0, 600, 400, 0);
        arm(1, 2, 0, 0, 'hAA);
        @(posedge clk); #1;
        st = 2'b00;
        wait_cyc(m_e[1] + 2);
        chk("lat_ofs",   0, o_done_cyc[0] - o_start_cyc[0], 19202);
        chk("nwr_ofs",   0, o_cnt[0], 3200);
        chk("faddr_ofs", 0, o_faddr[0], 256600);
        chk("fdata_ofs", 0, o_fdata[0], 0);
        fin(0);
        chk("nwr_fill", 1, o_cnt[1], 19200);
`ifdef PIXEL_COPY_FILL_EN
        chk("fdata_fill", 1, o_fdata[1], 'hAA);
        chk("d5_fill",    1, o_d5[1], 'hAA);
`else
        chk("fdata_fill", 1, o_fdata[1], 0);
        chk("d5_fill",    1, o_d5[1], 'h3C);
`endif
        fin(1);

        // A: abort in RUN cycle 100; B: start coinciding with abort while idle
        arm(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        st = 2'b00;
        wait_cyc(m_s[0] + 100);
        abort = 1'b1;
        st[1] = 1'b1;
        m_e[0] = cyc;
        m_wlast[0] = cyc;
        m_dok[0] = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", 0, int'(bsy[0]), 0);
        chk("abort_start_busy", 1, int'(bsy[1]), 0);
        abort = 1'b0;
        st = 2'b00;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_nwr",   0, o_cnt[0], 100);
        chk("abort_ndone", 0, o_ndone[0], 0);

        // A: full transfer after the abort, mode 11 behaves as copy
        arm(0, 3, 0, 0, 0);
        @(posedge clk); #1;
        st = 2'b00;
        wait_cyc(m_e[0] + 2);
        chk("lat_after_abort", 0, o_done_cyc[0] - o_start_cyc[0], 19202);
        chk("nwr_after_abort", 0, o_cnt[0], 19200);
        fin(0);

        // A: reset asserted mid-run
        arm(0, 0, 0, 0, 0);
        @(posedge clk); #1;
        st = 2'b00;
        wait_cyc(m_s[0] + 200);
        reset = 1'b0;
        m_act[0] = 1'b0;
        m_act[1] = 1'b0;
        #1;
        check_idle_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_src_addr", 0, int'(sa[0]), 0);
        chk("post_rst_busy",     0, int'(bsy[0]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
